// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: serialises IF fetches and MEM loads/stores onto one synchronous memory port, alternating grants under contention.
// Latency: request-to-valid MEM_LAT+2 cycles; misaligned requests take 1 cycle when ALIGN_CHECK_EN is defined.
// Backpressure: requesters hold their level req until the one-cycle valid pulse; pc_stall holds the PC while a fetch is pending.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_valid,
    output logic [DATA_W-1:0] fetch_data,
    output logic              fetch_err,
    input  logic              data_req,
    input  logic              data_we,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_valid,
    output logic [DATA_W-1:0] data_rdata,
    output logic              data_err,
    output logic              pc_stall,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic GNT_FETCH = 1'b0;
    localparam logic GNT_DATA  = 1'b1;

    localparam int            CW       = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(MEM_LAT - 1);

    logic [1:0]    state;
    logic          last_grant;
    logic          cur_grant;
    logic          cur_we;
    logic [CW-1:0] wait_cnt;

    logic grant_vld;
    logic grant_side;
    logic grant_mis;

    // Under contention the side that did not win last time gets the port.
    always_comb begin
        grant_vld  = fetch_req | data_req;
        grant_side = GNT_FETCH;
        grant_mis  = 1'b0;
        if (fetch_req && data_req)
            grant_side = ~last_grant;
        else if (data_req)
            grant_side = GNT_DATA;
`ifdef ALIGN_CHECK_EN
        grant_mis = (grant_side == GNT_DATA) ? (data_addr[1:0] != 2'b00)
                                             : (fetch_addr[1:0] != 2'b00);
`endif
    end

    assign pc_stall = fetch_req & ~fetch_valid;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state       <= S_IDLE;
            last_grant  <= GNT_FETCH;
            cur_grant   <= GNT_FETCH;
            cur_we      <= 1'b0;
            wait_cnt    <= '0;
            fetch_valid <= 1'b0;
            fetch_data  <= '0;
            data_valid  <= 1'b0;
            data_rdata  <= '0;
            mem_en      <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
        end else begin
            fetch_valid <= 1'b0;
            data_valid  <= 1'b0;
            mem_en      <= 1'b0;
            mem_we      <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (grant_vld) begin
                        last_grant <= grant_side;
                        cur_grant  <= grant_side;
                        cur_we     <= (grant_side == GNT_DATA) & data_we;
                        if (grant_mis) begin
                            // Rejected without touching memory: answer next cycle.
                            state       <= S_DONE;
                            fetch_valid <= (grant_side == GNT_FETCH);
                            data_valid  <= (grant_side == GNT_DATA);
                        end else begin
                            state    <= S_ISSUE;
                            mem_en   <= 1'b1;
                            mem_we   <= (grant_side == GNT_DATA) & data_we;
                            mem_addr <= (grant_side == GNT_DATA) ? data_addr : fetch_addr;
                            if (grant_side == GNT_DATA)
                                mem_wdata <= data_wdata;
                        end
                    end
                end
                S_ISSUE: begin
                    state    <= S_WAIT;
                    wait_cnt <= '0;
                end
                S_WAIT: begin
                    if (wait_cnt == CNT_LAST) begin
                        state <= S_DONE;
                        if (!cur_we) begin
                            if (cur_grant == GNT_DATA)
                                data_rdata <= mem_rdata;
                            else
                                fetch_data <= mem_rdata;
                        end
                        fetch_valid <= (cur_grant == GNT_FETCH);
                        data_valid  <= (cur_grant == GNT_DATA);
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef ALIGN_CHECK_EN
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            fetch_err <= 1'b0;
            data_err  <= 1'b0;
        end else begin
            fetch_err <= 1'b0;
            data_err  <= 1'b0;
            if (state == S_IDLE && grant_vld && grant_mis) begin
                fetch_err <= (grant_side == GNT_FETCH);
                data_err  <= (grant_side == GNT_DATA);
            end
        end
    end
`else
    assign fetch_err = 1'b0;
    assign data_err  = 1'b0;
`endif

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Responder side of the shared instruction/data memory port.
- Accepts instruction-fetch requests from the IF stage and load/store requests from the MEM stage, then serialises them onto the single synchronous memory block.
- Returns read data with a one-cycle valid pulse.
- Drives pc_stall so the IF stage holds PC (PCescreve low) until its fetch is served.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MEM_LAT, 2, memory read latency in cycles from mem_en to mem_rdata valid (≥1).

Ports:
- clock  in  1  system clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- fetch_req  in  ADDR_W?1  level request from IF; held until fetch_valid.
- fetch_addr  in  ADDR_W  PC value to fetch.
- fetch_valid  out  1  one-cycle pulse, fetch_data valid.
- fetch_data  out  DATA_W  fetched instruction.
- fetch_err  out  1  misaligned fetch flag, see Optional Feature.
- data_req  in  1  level request from MEM stage; held until data_valid.
- data_we  in  1  1 = store, 0 = load.
- data_addr  in  ADDR_W  ALU-computed address.
- data_wdata  in  DATA_W  store data.
- data_valid  out  1  one-cycle pulse: load data valid or store complete.
- data_rdata  out  DATA_W  load result.
- data_err  out  1  misaligned data flag, see Optional Feature.
- pc_stall  out  1  high while fetch_req pending and not yet answered.
- mem_en  out  1  memory access strobe, one cycle per access.
- mem_we  out  1  memory write enable, only with mem_en.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after mem_en.

(fetch_req width is 1.)

Behaviour:
- Reset (resetn low, asynchronous): state IDLE; all registered outputs 0 (fetch_valid, fetch_data, fetch_err, data_valid, data_rdata, data_err, mem_en, mem_we, mem_addr, mem_wdata); last_grant = FETCH; wait counter 0.
- States:
  - IDLE: sample requests.
  - ISSUE: mem_en=1 for this cycle only.
  - WAIT: count MEM_LAT cycles.
  - DONE: valid pulse.
- IDLE, cycle s, grant rule:
  - Neither request: stay in IDLE.
  - One request: grant it.
  - Both requests: grant the one not equal to last_grant (alternation, no starvation).
  - On a grant, latch address/we/wdata (fetch: we=0) and update last_grant.
- ISSUE at s+1: mem_en=1, mem_we as latched, mem_addr/mem_wdata as latched. mem_en/mem_we return to 0 in every other state.
- WAIT occupies s+2 .. s+1+MEM_LAT. In cycle s+1+MEM_LAT the block captures mem_rdata for loads and fetches.
- DONE at s+2+MEM_LAT:
  - Granted side's valid = 1 for exactly this cycle.
  - fetch_data or data_rdata updated for reads; data_rdata unchanged for stores.
  - Next state is IDLE.
- Request-to-valid latency: MEM_LAT+2 cycles.
- Requests are not sampled in ISSUE, WAIT or DONE. A requester must drop req in the cycle after valid. A req still high when IDLE samples is a new request.
- pc_stall = fetch_req & ~fetch_valid, combinational. It is never registered, so it drops in the DONE cycle.
- A data request never causes pc_stall by itself. pc_stall still rises if IF is waiting behind a data access.
- mem_addr/mem_wdata hold their last values outside ISSUE. Only mem_en qualifies them.
- Reset mid-access: the in-flight access is abandoned and no valid pulse is produced. Any memory response arriving after reset release is ignored. Requests are re-sampled from IDLE.
- Addresses are passed unmodified (byte address); no wrap logic.

Optional Feature:
- Macro ALIGN_CHECK_EN.
- When defined, in IDLE a granted request with addr[1:0] != 0:
  - Skips ISSUE/WAIT; no mem_en.
  - Goes directly to DONE next cycle (latency 1).
  - Pulses the valid of the granted side together with its err.
  - Leaves data outputs unchanged.
  - Still updates last_grant.
- When undefined: fetch_err and data_err are tied 0 and all addresses are issued unchanged.

Test Plan:
- resetn low 3 cycles with fetch_req=1 -> all registered outputs 0, mem_en never 1, pc_stall=1; after release fetch proceeds normally.
- MEM_LAT=2, fetch_req=1, fetch_addr=0x00000010 sampled at t, memory returns 0x8C220004 -> mem_en=1 and mem_addr=0x10 at t+1 only; fetch_valid=1 and fetch_data=0x8C220004 at t+4; pc_stall 1 for t..t+3, 0 at t+4.
- fetch_req and data_req (load 0x00000100, mem returns 0x0000002A) both high at t with last_grant=FETCH -> data served first, data_valid/data_rdata=0x2A at t+4; fetch sampled t+5, mem_en t+6, fetch_valid t+9; pc_stall high t..t+8.
- Store: data_we=1, data_addr=0x200, data_wdata=0xDEADBEEF at t -> mem_en=mem_we=1 with those values at t+1 only; data_valid at t+4; data_rdata unchanged.
- data_req and fetch_req held high continuously -> grant order D,F,D,F…, each mem_en 5 cycles apart (MEM_LAT=2).
- resetn pulsed low at t+2 of a fetch -> no fetch_valid for that access; after release new fetch at 0x14 completes with normal latency. With ALIGN_CHECK_EN, fetch_addr=0x13 -> no mem_en, fetch_valid=fetch_err=1 at t+1.
